// File: rtl/inst_cache_nway.sv
// -----------------------------------------------------------------------------
// inst_cache_nway
//
// N-way set-associative instruction cache between the fetch stage and the
// instruction memory port.
//   - per-set round-robin replacement (invalid ways are filled first)
//   - critical-word-first refill that wraps around the line
//   - registered hit path: o_valid one cycle after a hit is accepted
//   - sequential whole-cache flush, one set per cycle
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   stall         pipeline stall, blocks request acceptance only
//   i_req/i_addr  fetch request and byte address (bits [1:0] ignored)
//   o_ready       cache can accept a request (registered state only)
//   o_valid       one-cycle pulse, o_addr/o_data hold the delivered word
//   i_flush       one-cycle pulse, invalidate the whole cache
//   o_mem_req     memory word request, o_mem_addr held until i_mem_ack
//   i_mem_ack     i_mem_data carries the requested word this cycle
// -----------------------------------------------------------------------------
module inst_cache_nway #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 6,
  parameter int INDEX_WIDTH  = 7,
  parameter int WAYS         = 2,
  parameter int WAY_WIDTH    = (WAYS > 1) ? $clog2(WAYS) : 1,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_flush,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam int WORD_BITS = OFFSET_WIDTH - 2;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam int SETS      = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [TAG_WIDTH-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_WIDTH-1:0]  miss_index_q, miss_index_d;
  logic [WORD_BITS-1:0]    cursor_q, cursor_d;
  logic [WORD_BITS-1:0]    ack_cnt_q, ack_cnt_d;
  logic [WAY_WIDTH-1:0]    victim_q, victim_d;
  logic                    victim_ptr_q, victim_ptr_d;
  logic [INDEX_WIDTH-1:0]  set_cnt_q, set_cnt_d;
  logic                    o_valid_q, o_valid_d;
  logic [ADDR_WIDTH-1:0]   o_addr_q, o_addr_d;
  logic [DATA_WIDTH-1:0]   crit_data_q, crit_data_d;
  logic                    sel_crit_q, sel_crit_d;
  logic [WAY_WIDTH-1:0]    hit_way_q, hit_way_d;

  logic [WAY_WIDTH-1:0]    rr_ptr_q [SETS];

  // Request address split
  logic [WORD_BITS-1:0]    req_word;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [TAG_WIDTH-1:0]    req_tag;

  assign req_word  = i_addr[OFFSET_WIDTH-1:2];
  assign req_index = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag   = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  logic [WAYS-1:0]                 hit_w;
  logic [WAYS-1:0]                 way_valid;
  logic [WAYS-1:0][DATA_WIDTH-1:0] way_rd_data;
  logic                            hit_any;
  logic [WAY_WIDTH-1:0]            hit_way;
  logic [WAY_WIDTH-1:0]            victim_sel;
  logic                            victim_by_ptr;
  logic                            accept;
  logic                            miss_take;
  logic                            ack_fire;
  logic                            last_ack;

  assign o_ready   = (state_q == IDLE) && !flush_pending_q;
  // A flush in the same cycle wins over the request.
  assign accept    = i_req && o_ready && !stall && !i_flush;
  assign hit_any   = |hit_w;
  assign miss_take = accept && !hit_any;
  assign ack_fire  = (state_q == REFILL) && i_mem_ack;
  assign last_ack  = ack_fire && (ack_cnt_q == WORD_BITS'(WORDS - 1));

  // ---------------------------------------------------------------------------
  // Per-way storage: valid bits in flops (cleared by reset/flush), tag array
  // with combinational lookup, and a data RAM with a registered read port.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [SETS-1:0]       valid_q;
      logic [TAG_WIDTH-1:0]  tag_mem [SETS];
      logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS];
      logic [DATA_WIDTH-1:0] rd_data_q;

      assign way_valid[gi]   = valid_q[req_index];
      assign hit_w[gi]       = valid_q[req_index] && (tag_mem[req_index] == req_tag);
      assign way_rd_data[gi] = rd_data_q;

      always_ff @(posedge clk) begin
        if (last_ack && (victim_q == WAY_WIDTH'(gi))) begin
          tag_mem[miss_index_q] <= miss_tag_q;
        end
        if (ack_fire && (victim_q == WAY_WIDTH'(gi))) begin
          data_mem[{miss_index_q, cursor_q}] <= i_mem_data;
        end
      end

      // Read every way speculatively; the hit way is picked next cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q <= '0;
        end else if (accept) begin
          rd_data_q <= data_mem[{req_index, req_word}];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= '0;
        end else if (state_q == FLUSH) begin
          valid_q[set_cnt_q] <= 1'b0;
        end else begin
          // The victim is invalidated at miss time so a partially refilled
          // line can never hit.
          if (miss_take && (victim_sel == WAY_WIDTH'(gi))) begin
            valid_q[req_index] <= 1'b0;
          end
          if (last_ack && (victim_q == WAY_WIDTH'(gi))) begin
            valid_q[miss_index_q] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Hit way encoder (at most one way may hit)
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_w[w]) begin
        hit_way = hit_way | WAY_WIDTH'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the round-robin pointer.
  always_comb begin
    victim_sel    = rr_ptr_q[req_index];
    victim_by_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_sel    = WAY_WIDTH'(w);
        victim_by_ptr = 1'b0;
      end
    end
    if (WAYS == 1) begin
      victim_sel    = '0;
      victim_by_ptr = 1'b0;
    end
  end

  // Round-robin pointers, one per set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr_q[s] <= '0;
      end
    end else if (state_q == FLUSH) begin
      rr_ptr_q[set_cnt_q] <= '0;
    end else if (last_ack && victim_ptr_q) begin
      rr_ptr_q[miss_index_q] <= rr_ptr_q[miss_index_q] + WAY_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Controller next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    req_addr_d      = req_addr_q;
    miss_tag_d      = miss_tag_q;
    miss_index_d    = miss_index_q;
    cursor_d        = cursor_q;
    ack_cnt_d       = ack_cnt_q;
    victim_d        = victim_q;
    victim_ptr_d    = victim_ptr_q;
    set_cnt_d       = set_cnt_q;
    o_valid_d       = 1'b0;
    o_addr_d        = o_addr_q;
    crit_data_d     = crit_data_q;
    sel_crit_d      = sel_crit_q;
    hit_way_d       = hit_way_q;

    case (state_q)
      IDLE: begin
        if (i_flush) begin
          state_d   = FLUSH;
          set_cnt_d = '0;
        end else if (accept) begin
          if (hit_any) begin
            o_valid_d  = 1'b1;
            o_addr_d   = i_addr;
            sel_crit_d = 1'b0;
            hit_way_d  = hit_way;
          end else begin
            req_addr_d   = i_addr;
            miss_tag_d   = req_tag;
            miss_index_d = req_index;
            cursor_d     = req_word;
            ack_cnt_d    = '0;
            victim_d     = victim_sel;
            victim_ptr_d = victim_by_ptr;
            state_d      = REFILL;
          end
        end
      end

      REFILL: begin
        if (i_flush) begin
          flush_pending_d = 1'b1;
        end
        if (ack_fire) begin
          cursor_d  = cursor_q + WORD_BITS'(1);
          ack_cnt_d = ack_cnt_q + WORD_BITS'(1);
          // First returned word is the one the fetch stage is waiting for.
          if (ack_cnt_q == '0) begin
            o_valid_d   = 1'b1;
            o_addr_d    = req_addr_q;
            crit_data_d = i_mem_data;
            sel_crit_d  = 1'b1;
          end
          if (last_ack) begin
            set_cnt_d = '0;
            state_d   = (flush_pending_q || i_flush) ? FLUSH : IDLE;
          end
        end
      end

      FLUSH: begin
        set_cnt_d = set_cnt_q + INDEX_WIDTH'(1);
        if (set_cnt_q == INDEX_WIDTH'(SETS - 1)) begin
          flush_pending_d = 1'b0;
          state_d         = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
      req_addr_q      <= '0;
      miss_tag_q      <= '0;
      miss_index_q    <= '0;
      cursor_q        <= '0;
      ack_cnt_q       <= '0;
      victim_q        <= '0;
      victim_ptr_q    <= 1'b0;
      set_cnt_q       <= '0;
      o_valid_q       <= 1'b0;
      o_addr_q        <= '0;
      crit_data_q     <= '0;
      sel_crit_q      <= 1'b0;
      hit_way_q       <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      req_addr_q      <= req_addr_d;
      miss_tag_q      <= miss_tag_d;
      miss_index_q    <= miss_index_d;
      cursor_q        <= cursor_d;
      ack_cnt_q       <= ack_cnt_d;
      victim_q        <= victim_d;
      victim_ptr_q    <= victim_ptr_d;
      set_cnt_q       <= set_cnt_d;
      o_valid_q       <= o_valid_d;
      o_addr_q        <= o_addr_d;
      crit_data_q     <= crit_data_d;
      sel_crit_q      <= sel_crit_d;
      hit_way_q       <= hit_way_d;
    end
  end

  // Outputs
  assign o_valid    = o_valid_q;
  assign o_addr     = o_addr_q;
  assign o_data     = sel_crit_q ? crit_data_q : way_rd_data[hit_way_q];
  assign o_mem_req  = (state_q == REFILL);
  assign o_mem_addr = (state_q == REFILL) ? {miss_tag_q, miss_index_q, cursor_q, 2'b00}
                                          : '0;

  // A lookup must never match in more than one way.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == IDLE) && i_req) begin
      assert ($onehot0(hit_w));
    end
  end

endmodule

// File: tb/tb_inst_cache_nway.sv
// -----------------------------------------------------------------------------
// tb_inst_cache_nway
//
// Directed bench for inst_cache_nway (default parameters: 2 ways, 128 sets,
// 16-word lines). The memory model returns addr ^ 32'hC0DE0000 for each word
// and acknowledges every cycle that o_mem_req is high.
// -----------------------------------------------------------------------------
module tb_inst_cache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        i_req;
  logic [31:0] i_addr;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  always #5 clk = ~clk;

  inst_cache_nway dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .i_flush    (i_flush),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [31:0] v_addr [$];
  logic [31:0] v_data [$];
  int          v_cyc  [$];
  logic [31:0] mem_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every delivered word with the cycle it appeared in.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      v_addr.push_back(o_addr);
      v_data.push_back(o_data);
      v_cyc.push_back(cyc);
      $display("[TB] cyc %0d deliver addr=%h data=%h", cyc, o_addr, o_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    v_addr.delete();
    v_data.delete();
    v_cyc.delete();
    mem_log.delete();
  endtask

  // Issue one request for a single cycle.
  task automatic req_once(input logic [31:0] a);
    i_req  = 1'b1;
    i_addr = a;
    tick();
    i_req  = 1'b0;
    $display("[TB] cyc %0d request %h mem_req=%b", cyc, a, o_mem_req);
  endtask

  // Memory responder: acknowledge n words, optionally pulsing i_flush together
  // with ack number flush_at (0-based). Returns the cycle of the first ack.
  task automatic do_acks(input int n, input int flush_at, output int first_cyc);
    int got;
    int guard;
    got       = 0;
    guard     = 0;
    first_cyc = -1;
    while (got < n && guard < 200) begin
      if (o_mem_req === 1'b1) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem_fn(o_mem_addr);
        mem_log.push_back(o_mem_addr);
        i_flush    = (got == flush_at);
        got++;
      end else begin
        i_mem_ack = 1'b0;
        i_flush   = 1'b0;
      end
      tick();
      if (i_mem_ack && got == 1 && first_cyc < 0) first_cyc = cyc;
      guard++;
    end
    i_mem_ack = 1'b0;
    i_flush   = 1'b0;
    tests_run++;
    if (got != n) begin
      tests_failed++;
      $display("FAIL ack_budget: got %0d acks, want %0d", got, n);
    end
  endtask

  // Count cycles with o_ready low, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (o_ready !== 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests_run++;
    if (o_mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
    tests_run++;
    if (o_mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    tests_run++;
    if (o_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", o_addr); end
    tests_run++;
    if (o_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", o_data); end
  endtask

  task automatic test_miss_refill();
    int first_cyc;
    int bad;
    logic [31:0] exp_a;
    clear_logs();
    req_once(32'h0000_1008);
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL miss_ready: got %b want 0", o_ready); end
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1008) begin
      tests_failed++;
      $display("FAIL miss_first_addr: got req=%b addr=%h want req=1 addr=00001008", o_mem_req, o_mem_addr);
    end
    do_acks(16, -1, first_cyc);
    tests_run++;
    bad = (mem_log.size() != 16) ? 1 : 0;
    for (int k = 0; k < 16 && k < mem_log.size(); k++) begin
      exp_a = 32'h1000 + 32'(((2 + k) % 16) * 4);
      if (mem_log[k] !== exp_a && bad == 0) begin
        bad = 1;
        $display("FAIL wrap_seq: ack %0d got %h want %h", k, mem_log[k], exp_a);
      end
    end
    if (bad != 0) begin
      tests_failed++;
      if (mem_log.size() != 16) $display("FAIL wrap_seq_len: got %0d want 16", mem_log.size());
    end
    tests_run++;
    if (v_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL crit_count: got %0d deliveries want 1", v_addr.size());
    end else begin
      tests_run++;
      if (v_addr[0] !== 32'h1008 || v_data[0] !== 32'hC0DE1008) begin
        tests_failed++;
        $display("FAIL crit_word: got addr=%h data=%h want 00001008 c0de1008", v_addr[0], v_data[0]);
      end
      tests_run++;
      if (v_cyc[0] != first_cyc) begin
        tests_failed++;
        $display("FAIL crit_latency: got cyc %0d want %0d", v_cyc[0], first_cyc);
      end
    end
    tests_run++;
    if (o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL refill_done: got mem_req=%b ready=%b want 0 1", o_mem_req, o_ready);
    end
  endtask

  task automatic test_back_to_back_hits();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic        req_seen;
    int          acc_cyc;
    addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h103C;
    datas[0] = 32'hC0DE1000; datas[1] = 32'hC0DE1004; datas[2] = 32'hC0DE103C;
    clear_logs();
    req_seen = 1'b0;
    acc_cyc  = 0;
    i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = addrs[k];
      tick();
      if (k == 0) acc_cyc = cyc;
      req_seen = req_seen | o_mem_req;
    end
    i_req = 1'b0;
    tick();
    req_seen = req_seen | o_mem_req;
    tests_run++;
    if (req_seen !== 1'b0) begin tests_failed++; $display("FAIL hit_mem_req: got 1 want 0"); end
    tests_run++;
    if (v_addr.size() != 3) begin
      tests_failed++;
      $display("FAIL hit_count: got %0d want 3", v_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (v_addr[k] !== addrs[k] || v_data[k] !== datas[k] || v_cyc[k] != acc_cyc + k) begin
          tests_failed++;
          $display("FAIL hit_%0d: got addr=%h data=%h cyc=%0d want %h %h %0d",
                   k, v_addr[k], v_data[k], v_cyc[k], addrs[k], datas[k], acc_cyc + k);
        end
      end
    end
  endtask

  task automatic test_replacement();
    int fc;
    req_once(32'h3008);
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h3008) begin
      tests_failed++;
      $display("FAIL repl_miss_3008: got req=%b addr=%h want 1 00003008", o_mem_req, o_mem_addr);
    end
    do_acks(16, -1, fc);
    req_once(32'h5008);
    tests_run++;
    if (o_mem_req !== 1'b1) begin tests_failed++; $display("FAIL repl_miss_5008: got %b want 1", o_mem_req); end
    do_acks(16, -1, fc);
    clear_logs();
    req_once(32'h3008);
    tests_run++;
    if (o_mem_req !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'hC0DE3008) begin
      tests_failed++;
      $display("FAIL repl_hit_3008: got req=%b valid=%b data=%h want 0 1 c0de3008", o_mem_req, o_valid, o_data);
    end
    tick();
    req_once(32'h1008);
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1008) begin
      tests_failed++;
      $display("FAIL repl_evicted_1008: got req=%b addr=%h want 1 00001008", o_mem_req, o_mem_addr);
    end
    do_acks(16, -1, fc);
  endtask

  task automatic test_flush_during_refill();
    int fc;
    int busy;
    clear_logs();
    req_once(32'h7008);
    do_acks(16, 9, fc);
    tests_run++;
    if (mem_log.size() != 16 || o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_refill_len: got %0d acks mem_req=%b want 16 0", mem_log.size(), o_mem_req);
    end
    tests_run++;
    if (v_addr.size() != 1 || v_data.size() != 1 || v_data[0] !== 32'hC0DE7008) begin
      tests_failed++;
      $display("FAIL flush_refill_crit: got %0d deliveries want 1 of c0de7008", v_addr.size());
    end
    count_busy(busy);
    tests_run++;
    if (busy != 128) begin tests_failed++; $display("FAIL flush_after_refill_len: got %0d cycles want 128", busy); end
    req_once(32'h7008);
    tests_run++;
    if (o_mem_req !== 1'b1) begin tests_failed++; $display("FAIL flush_invalidates: got mem_req=%b want 1", o_mem_req); end
    do_acks(16, -1, fc);
  endtask

  task automatic test_stall();
    int  fc;
    logic req_seen;
    logic not_ready;
    req_seen  = 1'b0;
    not_ready = 1'b0;
    stall  = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h9008;
    for (int k = 0; k < 3; k++) begin
      tick();
      req_seen  = req_seen | o_mem_req;
      not_ready = not_ready | ~o_ready;
    end
    tests_run++;
    if (req_seen !== 1'b0 || not_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_blocks: got mem_req_seen=%b not_ready=%b want 0 0", req_seen, not_ready);
    end
    stall = 1'b0;
    tick();
    i_req = 1'b0;
    tests_run++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h9008) begin
      tests_failed++;
      $display("FAIL stall_release: got req=%b addr=%h want 1 00009008", o_mem_req, o_mem_addr);
    end
    do_acks(16, -1, fc);
  endtask

  task automatic test_req_flush_same_cycle();
    int busy;
    clear_logs();
    i_req   = 1'b1;
    i_addr  = 32'h9008;
    i_flush = 1'b1;
    tick();
    i_req   = 1'b0;
    i_flush = 1'b0;
    tests_run++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_flush_drop: got valid=%b ready=%b want 0 0", o_valid, o_ready);
    end
    count_busy(busy);
    tests_run++;
    if (busy != 128) begin tests_failed++; $display("FAIL idle_flush_len: got %0d cycles want 128", busy); end
    tests_run++;
    if (v_addr.size() != 0) begin tests_failed++; $display("FAIL req_flush_no_valid: got %0d deliveries want 0", v_addr.size()); end
  endtask

  task automatic test_reset_mid_refill();
    int fc;
    req_once(32'h1008);
    tests_run++;
    if (o_mem_req !== 1'b1) begin tests_failed++; $display("FAIL post_flush_miss: got %b want 1", o_mem_req); end
    do_acks(16, -1, fc);
    req_once(32'h9008);
    do_acks(5, -1, fc);
    rst = 1'b1;
    tick();
    tests_run++;
    if (o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_refill: got req=%b ready=%b valid=%b maddr=%h want 0 1 0 0",
               o_mem_req, o_ready, o_valid, o_mem_addr);
    end
    rst = 1'b0;
    tick();
    req_once(32'h1008);
    tests_run++;
    if (o_mem_req !== 1'b1) begin tests_failed++; $display("FAIL rst_clears_valid: got mem_req=%b want 1", o_mem_req); end
    do_acks(16, -1, fc);
    req_once(32'h9008);
    tests_run++;
    if (o_mem_req !== 1'b1) begin tests_failed++; $display("FAIL rst_partial_line: got mem_req=%b want 1", o_mem_req); end
    do_acks(16, -1, fc);
    req_once(32'h9008);
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== 32'hC0DE9008 || o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_refill_hit: got valid=%b data=%h req=%b want 1 c0de9008 0", o_valid, o_data, o_mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_back_to_back_hits();
    test_replacement();
    test_flush_during_refill();
    test_stall();
    test_req_flush_same_cycle();
    test_reset_mid_refill();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
